param_data_memory: RTL and testbench
====================================

# param_data_memory

Parametrised single-port data memory, the next generation of the processor's instruction/data memories. It adds configurable data width and depth, a registered read with a valid strobe, and address-range checking. A hardware clear sequencer sweeps every word to a known value after reset or on request. It sits between the datapath's load/store unit and the register file write-back path.

## Interface
- DATA_WIDTH, 8, bits per word
- DEPTH, 256, number of words; need not be a power of two; minimum 2
- ADDR_WIDTH, $clog2(DEPTH), address bus width
- INIT_VALUE, 0, value written to every word by the clear sequencer
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  read request, sampled at posedge
- mem_write  in  1  write request, sampled at posedge
- access_addr  in  ADDR_WIDTH  word address for read and write
- write_data  in  DATA_WIDTH  write data
- clear_req  in  1  one-cycle pulse that restarts the clear sweep; honoured only in IDLE
- read_data  out  DATA_WIDTH  registered read data; holds its value between reads
- read_valid  out  1  one-cycle strobe qualifying read_data
- addr_err  out  1  one-cycle strobe: the previous cycle's access was out of range
- init_busy  out  1  high while the clear sweep runs; accesses are ignored

## Operation
- State machine with two states, CLEAR and IDLE; a clear counter of ADDR_WIDTH bits.
- Reset (rst_n low, asynchronous): state=CLEAR, counter=0, read_data=0, read_valid=0, addr_err=0, init_busy=1.
- Array contents are not reset directly; the CLEAR sweep initialises them.
- CLEAR:
  - Each cycle: ram[counter] <= INIT_VALUE, then counter increments.
  - When counter == DEPTH-1 is written, go to IDLE next cycle. The sweep takes exactly DEPTH cycles.
  - mem_read, mem_write and clear_req are ignored. read_valid=0, addr_err=0.
- IDLE:
  - clear_req=1: counter=0, state=CLEAR next cycle; any access in the same cycle is ignored.
  - In-range write (addr < DEPTH): ram[addr] <= write_data.
  - In-range read: read_data <= ram[addr] and read_valid <= 1 on the next edge.
  - Read and write of the same address in the same cycle are read-first: read_data returns the old contents.
  - Out-of-range access (addr >= DEPTH, only possible when DEPTH is not a power of two):
    - A write is dropped.
    - A read gives read_data <= 0 with read_valid <= 1.
    - addr_err <= 1 for one cycle in both cases.
  - No request: read_valid <= 0, addr_err <= 0, read_data holds.
- Reset asserted mid-sweep or mid-access: the sweep restarts from 0 after release; an in-flight read produces no read_valid.

## Timing
- Read latency 1 cycle: request at edge N gives data and read_valid after edge N+1, valid for one cycle.
- Back-to-back reads every cycle are supported; read_valid stays high continuously.
- Write takes effect at edge N; a read of the same address at edge N+1 returns the new data.
- init_busy falls DEPTH cycles after rst_n release (first posedge after release counts as sweep cycle 0).
- addr_err and read_valid for the same request assert in the same cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset release, DEPTH=256 -> init_busy high for exactly 256 cycles. Then a read at address 0x00, 0x7F and 0xFF each returns 0x00 with read_valid=1 one cycle after request.
- Write 0xA5 to 0x10, then read 0x10 next cycle -> read_data=0xA5, read_valid=1 one cycle later. Then idle -> read_valid=0, read_data stays 0xA5.
- Same cycle: write 0x3C and read of 0x20, which holds 0x11 -> read_data=0x11. A following read returns 0x3C.
- DEPTH=200, DATA_WIDTH=16:
  - Write 0xBEEF to address 210 -> addr_err pulse, no array change.
  - Read 210 -> read_data=0x0000, read_valid=1, addr_err=1.
- Write 0x55 to 0x05, pulse clear_req -> init_busy for DEPTH cycles, accesses ignored meanwhile; then read 0x05 -> INIT_VALUE.
- Assert rst_n low halfway through the sweep and during a pending read -> outputs go to reset values immediately, no read_valid. After release a full DEPTH-cycle sweep runs.

Source files
------------

// File: rtl/param_data_memory.sv
// param_data_memory: parametrised single-port data memory with registered read, range check and clear sweep
module param_data_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] access_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  addr_err,
  output logic                  init_busy
);
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic [ADDR_WIDTH:0] depth_w = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] last = ADDR_WIDTH'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] counter_q, counter_d, ram_addr;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d, ram_wdata;
  logic read_valid_q, read_valid_d, addr_err_q, addr_err_d, init_busy_q, init_busy_d;
  logic idle, in_range, rd, wr, ram_we;
  always_comb begin
    idle = state_q == IDLE;
    in_range = {1'b0, access_addr} < depth_w;
    rd = idle && !clear_req && mem_read;
    wr = idle && !clear_req && mem_write;
    state_d = idle ? (clear_req ? CLEAR : IDLE) : (counter_q == last ? IDLE : CLEAR);
    counter_d = idle ? '0 : counter_q + ADDR_WIDTH'(1);
    init_busy_d = state_d == CLEAR;
    read_valid_d = rd;
    addr_err_d = (rd || wr) && !in_range;
    read_data_d = rd ? (in_range ? ram[access_addr] : '0) : read_data_q;
    ram_we = !idle || (wr && in_range);
    ram_addr = idle ? access_addr : counter_q;
    ram_wdata = idle ? write_data : INIT_VALUE;
  end
  // array has no reset; the clear sweep initialises it
  always_ff @(posedge clk)
    if (ram_we) ram[ram_addr] <= ram_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLEAR;
      counter_q <= '0;
      read_data_q <= '0;
      read_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      counter_q <= counter_d;
      read_data_q <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_err_q <= addr_err_d;
      init_busy_q <= init_busy_d;
    end
  assign read_data = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_err = addr_err_q;
  assign init_busy = init_busy_q;
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: directed checks on a default instance and a 200x16 instance with non-zero init
module tb_param_data_memory;
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_rd = 0, a_wr = 0, a_clr = 0;
  logic [7:0] a_addr = '0, a_wd = '0, a_rdata;
  logic a_valid, a_err, a_busy;
  logic b_rd = 0, b_wr = 0, b_clr = 0;
  logic [7:0] b_addr = '0;
  logic [15:0] b_wd = '0, b_rdata;
  logic b_valid, b_err, b_busy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  param_data_memory u_a (
    .clk(clk), .rst_n(rst_n), .mem_read(a_rd), .mem_write(a_wr), .access_addr(a_addr),
    .write_data(a_wd), .clear_req(a_clr), .read_data(a_rdata), .read_valid(a_valid),
    .addr_err(a_err), .init_busy(a_busy)
  );
  param_data_memory #(.DATA_WIDTH(16), .DEPTH(200), .INIT_VALUE(16'h5A5A)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_read(b_rd), .mem_write(b_wr), .access_addr(b_addr),
    .write_data(b_wd), .clear_req(b_clr), .read_data(b_rdata), .read_valid(b_valid),
    .addr_err(b_err), .init_busy(b_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic a_op(input logic r, input logic w, input logic [7:0] ad, input logic [7:0] d);
    a_rd = r; a_wr = w; a_addr = ad; a_wd = d;
    step();
    a_rd = 0; a_wr = 0;
  endtask
  task automatic b_op(input logic r, input logic w, input logic [7:0] ad, input logic [15:0] d);
    b_rd = r; b_wr = w; b_addr = ad; b_wd = d;
    step();
    b_rd = 0; b_wr = 0;
  endtask
  task automatic sweep_len(input string tag, input int exp_a, input int exp_b);
    int na = 0, nb = 0, n = 0;
    while ((a_busy || b_busy) && n < 1000) begin
      na += int'(a_busy);
      nb += int'(b_busy);
      step();
      n++;
    end
    chk({tag, "_a"}, na, exp_a);
    chk({tag, "_b"}, nb, exp_b);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    step();
    chk("rst_data", a_rdata, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_err", a_err, 0);
    chk("rst_busy", a_busy, 1);
    rst_n = 1;
    sweep_len("init_len", 256, 200);
    a_op(1, 0, 8'h00, 0); chk("rd00_v", a_valid, 1); chk("rd00_d", a_rdata, 0);
    a_op(1, 0, 8'h7F, 0); chk("rd7f_v", a_valid, 1); chk("rd7f_d", a_rdata, 0);
    a_op(1, 0, 8'hFF, 0); chk("rdff_v", a_valid, 1); chk("rdff_d", a_rdata, 0); chk("rdff_e", a_err, 0);
    a_op(0, 1, 8'h10, 8'hA5); chk("wr_v", a_valid, 0);
    a_op(1, 0, 8'h10, 0); chk("rd10_v", a_valid, 1); chk("rd10_d", a_rdata, 8'hA5);
    step(); chk("idle_v", a_valid, 0); chk("idle_d", a_rdata, 8'hA5);
    a_op(0, 1, 8'h20, 8'h11);
    a_op(1, 1, 8'h20, 8'h3C); chk("rf_d", a_rdata, 8'h11); chk("rf_v", a_valid, 1);
    a_op(1, 0, 8'h20, 0); chk("rf_new", a_rdata, 8'h3C);
    a_op(0, 1, 8'h05, 8'h55);
    a_clr = 1; a_op(1, 0, 8'h05, 0); a_clr = 0;
    chk("clr_v", a_valid, 0); chk("clr_busy", a_busy, 1);
    for (int i = 0; i < 10; i++) step();
    a_op(1, 1, 8'h02, 8'h77); chk("sweep_rd_v", a_valid, 0);
    begin
      int n = 11;
      while (a_busy && n < 1000) begin step(); n++; end
      chk("clr_len", n, 256);
    end
    a_op(1, 0, 8'h05, 0); chk("clr05", a_rdata, 0);
    a_op(1, 0, 8'h02, 0); chk("clr02", a_rdata, 0);
    a_op(1, 0, 8'h20, 0); chk("clr20", a_rdata, 0);
    b_op(1, 0, 8'd0, 0); chk("b_rd0", b_rdata, 16'h5A5A); chk("b_rd0_v", b_valid, 1);
    b_op(1, 0, 8'd199, 0); chk("b_rd199", b_rdata, 16'h5A5A); chk("b_rd199_e", b_err, 0);
    b_op(0, 1, 8'd210, 16'hBEEF); chk("b_wr210_e", b_err, 1); chk("b_wr210_v", b_valid, 0);
    b_op(1, 0, 8'd210, 0);
    chk("b_rd210_d", b_rdata, 0); chk("b_rd210_v", b_valid, 1); chk("b_rd210_e", b_err, 1);
    step(); chk("b_err_clr", b_err, 0); chk("b_v_clr", b_valid, 0);
    b_op(0, 1, 8'd199, 16'h1234);
    b_op(1, 0, 8'd199, 0); chk("b_wr199", b_rdata, 16'h1234); chk("b_wr199_e", b_err, 0);
    a_op(0, 1, 8'h30, 8'h99);
    a_op(1, 0, 8'h30, 0); chk("pre_rst", a_rdata, 8'h99);
    a_rd = 1; a_addr = 8'h30;
    #2 rst_n = 0;
    #1 chk("arst_d", a_rdata, 0); chk("arst_v", a_valid, 0); chk("arst_busy", a_busy, 1);
    chk("arst_bd", b_rdata, 0);
    step(); chk("arst_hold_v", a_valid, 0);
    a_rd = 0;
    rst_n = 1;
    for (int i = 0; i < 100; i++) step();
    rst_n = 0;
    #1 chk("mid_busy", a_busy, 1);
    step();
    rst_n = 1;
    sweep_len("re_len", 256, 200);
    a_op(1, 0, 8'h30, 0); chk("re30", a_rdata, 0); chk("re30_v", a_valid, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
